// File: rtl/wptr_full.sv
// Async FIFO write-side pointer logic: binary/gray write pointer,
// full, almost-full, fill level and sticky overflow in the write domain.
module wptr_full #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] THRESH =
    (ADDRSIZE+1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] full_cmp;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] level_next;

  assign wen        = winc & ~wfull;
  assign waddr      = wbin[ADDRSIZE-1:0];
  assign wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                     wq2_rptr[ADDRSIZE-2:0]};

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  assign level_next = wbin_next - rbin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == full_cmp);
      walmost_full <= (level_next >= THRESH);
      wlevel       <= level_next;
      if (winc & wfull) begin
        woverflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full: directed vector table, async reset, wrap,
// and randomized traffic against a count-based reference model.
module tb_wptr_full;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int checks = 0;
  int errors = 0;

  wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(14)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       winc;
    logic [4:0] rptr;
    logic       pre_wen;
    logic [3:0] pre_waddr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
  } vec_t;

  vec_t tbl[20];

  // Reference model: plain write/read counts.
  int wcount;
  int rcount;
  bit m_full;
  bit m_ovf;

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    wcount = 0;
    rcount = 0;
    m_full = 0;
    m_ovf  = 0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Starts and ends at a negedge.
  task automatic model_step(input logic wi, input int rc);
    int lvl;
    winc     = wi;
    rcount   = rc;
    wq2_rptr = gray(rc);
    #1;
    chk("m_wen", wen, wi & ~m_full);
    chk("m_waddr_pre", waddr, wcount % 16);
    @(posedge clk);
    if (wi && m_full) m_ovf = 1;
    if (wi && !m_full) wcount++;
    lvl    = wcount - rcount;
    m_full = (lvl == 16);
    #1;
    chk("m_waddr", waddr, wcount % 16);
    chk("m_wptr", wptr, gray(wcount));
    chk("m_wfull", wfull, m_full);
    chk("m_afull", walmost_full, lvl >= 14);
    chk("m_level", wlevel, lvl);
    chk("m_ovf", woverflow, m_ovf);
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] prev;
    bit seen_wrap;
    bit saw_full;

    for (int i = 1; i <= 16; i++) begin
      tbl[i-1].winc      = 1'b1;
      tbl[i-1].rptr      = 5'd0;
      tbl[i-1].pre_wen   = 1'b1;
      tbl[i-1].pre_waddr = 4'((i - 1) % 16);
      tbl[i-1].waddr     = 4'(i % 16);
      tbl[i-1].wptr      = gray(i);
      tbl[i-1].full      = (i == 16);
      tbl[i-1].afull     = (i >= 14);
      tbl[i-1].level     = 5'(i);
      tbl[i-1].ovf       = 1'b0;
    end
    tbl[16] = '{1'b1, 5'b00000, 1'b0, 4'd0, 4'd0, 5'b11000,
                1'b1, 1'b1, 5'd16, 1'b1};
    tbl[17] = '{1'b0, 5'b00000, 1'b0, 4'd0, 4'd0, 5'b11000,
                1'b1, 1'b1, 5'd16, 1'b1};
    tbl[18] = '{1'b0, 5'b00110, 1'b0, 4'd0, 4'd0, 5'b11000,
                1'b0, 1'b0, 5'd12, 1'b1};
    tbl[19] = '{1'b1, 5'b00110, 1'b1, 4'd0, 4'd1, 5'b11001,
                1'b0, 1'b0, 5'd13, 1'b1};

    // Reset with writes requested
    rst      = 1'b1;
    winc     = 1'b1;
    wq2_rptr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wptr", wptr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_ovf", woverflow, 0);
    chk("rst_afull", walmost_full, 0);
    chk("rst_wen", wen, 1);
    rst = 1'b0;

    // Fill, overflow, release, resume
    for (int i = 0; i < 20; i++) begin
      winc     = tbl[i].winc;
      wq2_rptr = tbl[i].rptr;
      #1;
      chk($sformatf("t%0d_wen", i), wen, tbl[i].pre_wen);
      chk($sformatf("t%0d_waddr_pre", i), waddr, tbl[i].pre_waddr);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_waddr", i), waddr, tbl[i].waddr);
      chk($sformatf("t%0d_wptr", i), wptr, tbl[i].wptr);
      chk($sformatf("t%0d_wfull", i), wfull, tbl[i].full);
      chk($sformatf("t%0d_afull", i), walmost_full, tbl[i].afull);
      chk($sformatf("t%0d_level", i), wlevel, tbl[i].level);
      chk($sformatf("t%0d_ovf", i), woverflow, tbl[i].ovf);
      @(negedge clk);
    end

    // Async reset between edges after 5 writes
    reset_pulse();
    repeat (5) model_step(1'b1, 0);
    winc = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wptr", wptr, 0);
    chk("arst_waddr", waddr, 0);
    chk("arst_level", wlevel, 0);
    chk("arst_wen", wen, 1);
    @(posedge clk);
    #1;
    chk("arst_hold_waddr", waddr, 0);
    chk("arst_hold_wptr", wptr, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_step(1'b1, 0);

    // Wrap with the reader trailing two behind
    reset_pulse();
    prev      = wptr;
    seen_wrap = 0;
    saw_full  = 0;
    for (int i = 0; i < 40; i++) begin
      model_step(1'b1, wcount - 2);
      chk("wrap_onebit", $countones(prev ^ wptr) <= 1, 1);
      if (prev == 5'b10000 && wptr == 5'b00000) seen_wrap = 1;
      if (wfull) saw_full = 1;
      prev = wptr;
    end
    chk("wrap_seen", seen_wrap, 1);
    chk("wrap_nofull", saw_full, 0);
    model_step(1'b0, wcount - 2);
    chk("wrap_level", wlevel, 2);

    // Random traffic: slow reader, then fast reader
    reset_pulse();
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 600; i++) begin
        int rc;
        logic wi;
        rc = rcount;
        if (rc < wcount &&
            $urandom_range(0, 9) < (ph == 0 ? 4 : 9)) rc++;
        wi = ($urandom_range(0, 9) < (ph == 0 ? 7 : 5));
        prev = wptr;
        model_step(wi, rc);
        chk("rnd_onebit", $countones(prev ^ wptr) <= 1, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
